alu_seq: RTL

- Parametrised, registered successor of the 8-bit combinational ALU: WIDTH-bit add/sub/logic plus a multi-cycle unsigned shift-add multiplier.
- Adds a persistent carry flag for multi-word arithmetic (ADC/SBC) and valid/ready handshakes on input and output.
- Sits between the operand register file and the writeback stage of the datapath.

---
 rtl/alu_seq_if.sv | 11 +
 rtl/alu_seq.sv | 109 ++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle between the register file, alu_seq and writeback
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] a, b, r, r_hi;
  logic [3:0]       alu_op;
  logic             c_out, z, v, n;
  modport master (output in_valid, a, b, alu_op, out_ready,
                  input  in_ready, out_valid, r, r_hi, c_out, z, v, n);
  modport slave  (input  in_valid, a, b, alu_op, out_ready,
                  output in_ready, out_valid, r, r_hi, c_out, z, v, n);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with persistent carry, multi-cycle shift-add multiplier and valid/ready handshakes
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave io
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   r_q, r_d, rh_q, rh_d, mc_q, mc_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               c_q, c_d, z_q, z_d, v_q, v_d, n_q, n_d;
  logic               acc, is_mul, is_arith, is_sub, cin;
  logic [WIDTH-1:0]   bb, res;
  logic [WIDTH:0]     sum, step;
  assign io.in_ready  = state_q == IDLE || (state_q == DONE && io.out_ready);
  assign io.out_valid = state_q == DONE;
  assign io.r         = r_q;
  assign io.r_hi      = rh_q;
  assign io.c_out     = c_q;
  assign io.z         = z_q;
  assign io.v         = v_q;
  assign io.n         = n_q;
  assign acc      = io.in_valid && io.in_ready;
  assign is_mul   = MUL_EN && io.alu_op == 4'b1000;
  assign is_arith = io.alu_op[3:2] == 2'b00;
  assign is_sub   = is_arith && io.alu_op[1];
  assign bb       = is_sub ? ~io.b : io.b;
  // ADD/SUB inject 0/1, ADC/SBC inject the stored carry
  assign cin      = io.alu_op[0] ? c_q : io.alu_op[1];
  assign sum      = {1'b0, io.a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
  assign res      = is_arith ? sum[WIDTH-1:0] :
                    io.alu_op == 4'd4 ? io.a & io.b :
                    io.alu_op == 4'd5 ? io.a | io.b :
                    io.alu_op == 4'd6 ? io.a ^ io.b :
                    io.alu_op == 4'd7 ? io.b : io.a;
  // one multiplier step: add multiplicand into the high half if the current multiplier bit is set
  assign step     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mc_q} : '0);
  // next state, result/flag loading and multiplier iteration
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    rh_d    = rh_q;
    mc_d    = mc_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    z_d     = z_q;
    v_d     = v_q;
    n_d     = n_q;
    if (acc && is_mul) begin
      state_d = BUSY;
      p_d     = {{WIDTH{1'b0}}, io.b};
      mc_d    = io.a;
      cnt_d   = '0;
    end else if (acc) begin
      state_d = DONE;
      r_d     = res;
      rh_d    = '0;
      z_d     = res == '0;
      n_d     = res[WIDTH-1];
      v_d     = is_arith && io.a[WIDTH-1] == bb[WIDTH-1] && sum[WIDTH-1] != io.a[WIDTH-1];
      c_d     = is_arith ? sum[WIDTH] : c_q;
    end else if (state_q == BUSY && cnt_q == LAST) begin
      state_d = DONE;
      r_d     = p_q[WIDTH-1:0];
      rh_d    = p_q[2*WIDTH-1:WIDTH];
      z_d     = p_q == '0;
      n_d     = p_q[2*WIDTH-1];
      v_d     = p_q[2*WIDTH-1:WIDTH] != '0;
    end else if (state_q == BUSY) begin
      p_d     = {step, p_q[WIDTH-1:1]};
      cnt_d   = cnt_q + CW'(1);
    end else if (state_q == DONE && io.out_ready) begin
      state_d = IDLE;
    end
  end
  // state and datapath registers; reset abandons any multiply in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      rh_q    <= '0;
      mc_q    <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      rh_q    <= rh_d;
      mc_q    <= mc_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      z_q     <= z_d;
      v_q     <= v_d;
      n_q     <= n_d;
    end
  end
endmodule
